// File: rtl/icache_refill_bridge_if.sv
// ---------------------------------------------------------------------------
// icache_refill_bridge_if
//   Bundles the two bus faces of the icache refill bridge:
//     - downstream_txreq_* : miss requests from icache_top (addr + entry id)
//     - downstream_rxdat_* : completed refill lines back to icache_top
//     - mem_ar_*           : line-aligned read requests to memory/L2
//     - mem_r_*            : multi-beat read data from memory/L2
//   Modports:
//     slave  : the bridge itself (accepts txreq, issues ar, consumes r,
//              produces rxdat)
//     master : the environment around the bridge (icache_top + memory side)
//
//   Handshake rule for every *_vld/*_rdy pair: a transfer happens on a rising
//   clock edge where vld and rdy are both high. Once raised, vld and its
//   payload hold stable until that edge. vld never depends on rdy; rdy may
//   look at the payload presented with vld (txreq_rdy looks at entry_id).
// ---------------------------------------------------------------------------
interface icache_refill_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int ENTRY_ID_W = 3,
    parameter int LINE_W     = 256,
    parameter int BEAT_W     = 64
);
    logic                  downstream_txreq_vld;
    logic                  downstream_txreq_rdy;
    logic [ADDR_WIDTH-1:0] downstream_txreq_pld;
    logic [ENTRY_ID_W-1:0] downstream_txreq_entry_id;

    logic                  downstream_rxdat_vld;
    logic                  downstream_rxdat_rdy;
    logic [LINE_W-1:0]     downstream_rxdat_pld;
    logic [ENTRY_ID_W-1:0] downstream_rxdat_entry_id;

    logic                  mem_ar_vld;
    logic                  mem_ar_rdy;
    logic [ADDR_WIDTH-1:0] mem_ar_addr;
    logic [ENTRY_ID_W-1:0] mem_ar_id;

    logic                  mem_r_vld;
    logic                  mem_r_rdy;
    logic [BEAT_W-1:0]     mem_r_data;
    logic [ENTRY_ID_W-1:0] mem_r_id;
    logic                  mem_r_last;

    modport master (
        output downstream_txreq_vld, downstream_txreq_pld, downstream_txreq_entry_id,
        output downstream_rxdat_rdy,
        output mem_ar_rdy,
        output mem_r_vld, mem_r_data, mem_r_id, mem_r_last,
        input  downstream_txreq_rdy,
        input  downstream_rxdat_vld, downstream_rxdat_pld, downstream_rxdat_entry_id,
        input  mem_ar_vld, mem_ar_addr, mem_ar_id,
        input  mem_r_rdy
    );

    modport slave (
        input  downstream_txreq_vld, downstream_txreq_pld, downstream_txreq_entry_id,
        input  downstream_rxdat_rdy,
        input  mem_ar_rdy,
        input  mem_r_vld, mem_r_data, mem_r_id, mem_r_last,
        output downstream_txreq_rdy,
        output downstream_rxdat_vld, downstream_rxdat_pld, downstream_rxdat_entry_id,
        output mem_ar_vld, mem_ar_addr, mem_ar_id,
        output mem_r_rdy
    );
endinterface

// File: rtl/icache_refill_bridge.sv
// ---------------------------------------------------------------------------
// icache_refill_bridge
//   Sits below icache_top. Turns icache miss requests into line-aligned
//   memory reads, gathers the returning beats (possibly interleaved across
//   ids) into per-entry line buffers, and hands each completed line back to
//   icache_top tagged with its entry id.
//
// Ports:
//   clk             clock
//   rst_n           synchronous reset, active HIGH despite the name
//   bus             icache_refill_bridge_if.slave (txreq, rxdat, mem ar, mem r)
//   outstanding_cnt number of entries not in IDLE
//   err_o           sticky protocol error (bad last/beat count, stray beat)
//   state_dbg       per-entry FSM state, entry i in bits [2*i+1:2*i]
//                   (0 IDLE, 1 REQ, 2 FILL, 3 DONE)
// ---------------------------------------------------------------------------
module icache_refill_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int ENTRY_NUM  = 8,
    parameter int ENTRY_ID_W = 3,
    parameter int LINE_W     = 256,
    parameter int BEAT_W     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    icache_refill_bridge_if.slave  bus,
    output logic [ENTRY_ID_W:0]    outstanding_cnt,
    output logic                   err_o,
    output logic [2*ENTRY_NUM-1:0] state_dbg
);
    localparam int BEATS      = LINE_W / BEAT_W;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_BYTES = LINE_W / 8;

    localparam logic [CNT_W-1:0]      LAST_SLOT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [ENTRY_ID_W:0]   OCNT_ONE  = (ENTRY_ID_W + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(ADDR_WIDTH'(LINE_BYTES - 1));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } entry_state_e;

    entry_state_e          state_q [ENTRY_NUM];
    logic [CNT_W-1:0]      cnt_q   [ENTRY_NUM];
    logic [LINE_W-1:0]     line_q  [ENTRY_NUM];

    // Single AR holding slot
    logic                  ar_vld_q;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [ENTRY_ID_W-1:0] ar_id_q;

    // Registered line return
    logic                  rx_vld_q;
    logic [LINE_W-1:0]     rx_pld_q;
    logic [ENTRY_ID_W-1:0] rx_id_q;

    logic [ENTRY_ID_W:0]   out_cnt_q;
    logic                  err_q;

    logic [ENTRY_NUM-1:0]  pend;
    logic [ENTRY_NUM-1:0]  done_vec;
    logic                  tx_fire;
    logic                  ar_fire;
    logic                  r_fire;
    logic                  rx_fire;
    logic [ENTRY_ID_W-1:0] r_id;
    entry_state_e          r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_live;
    logic                  r_done;
    logic                  r_bad;
    logic                  sel_found;
    logic [ENTRY_ID_W-1:0] sel_id;
    logic [LINE_W-1:0]     sel_line;

    always_comb begin
        pend = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            pend[i] = (state_q[i] != S_IDLE);
        end
    end

    // pend is the pre-update view, so a line being returned this cycle still
    // blocks a new request to the same entry until the next cycle.
    assign bus.downstream_txreq_rdy = !pend[bus.downstream_txreq_entry_id] &&
                                      (!ar_vld_q || bus.mem_ar_rdy);
    assign bus.mem_r_rdy            = !rst_n;

    assign tx_fire = bus.downstream_txreq_vld && bus.downstream_txreq_rdy;
    assign ar_fire = ar_vld_q && bus.mem_ar_rdy;
    assign r_fire  = bus.mem_r_vld && bus.mem_r_rdy;
    assign rx_fire = rx_vld_q && bus.downstream_rxdat_rdy;

    assign r_id    = bus.mem_r_id;
    assign r_state = state_q[r_id];
    assign r_cnt   = cnt_q[r_id];
    // Data may overtake the AR handshake, so REQ accepts beats as well.
    assign r_live  = r_fire && ((r_state == S_REQ) || (r_state == S_FILL));
    assign r_done  = r_live && bus.mem_r_last;
    assign r_bad   = r_fire && (!r_live ||
                                (bus.mem_r_last && (r_cnt != LAST_SLOT)) ||
                                (!bus.mem_r_last && (r_cnt == LAST_SLOT)));

    // Candidates for return include a line completing on this very beat so
    // the line reaches rxdat one cycle after its last beat.
    always_comb begin
        done_vec = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            done_vec[i] = (state_q[i] == S_DONE) ||
                          (r_done && (r_id == ENTRY_ID_W'(i)));
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (done_vec[i]) begin
                sel_found = 1'b1;
                sel_id    = ENTRY_ID_W'(i);
            end
        end
    end

    always_comb begin
        sel_line = line_q[sel_id];
        if (r_done && (sel_id == r_id)) begin
            sel_line[int'(r_cnt)*BEAT_W +: BEAT_W] = bus.mem_r_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
            ar_vld_q  <= 1'b0;
            ar_addr_q <= '0;
            ar_id_q   <= '0;
            rx_vld_q  <= 1'b0;
            rx_pld_q  <= '0;
            rx_id_q   <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (ar_fire) begin
                ar_vld_q <= 1'b0;
                // An entry that already completed on early data stays DONE.
                if (state_q[ar_id_q] == S_REQ) begin
                    state_q[ar_id_q] <= S_FILL;
                end
            end

            if (tx_fire) begin
                ar_vld_q  <= 1'b1;
                ar_addr_q <= bus.downstream_txreq_pld & LINE_MASK;
                ar_id_q   <= bus.downstream_txreq_entry_id;
                state_q[bus.downstream_txreq_entry_id] <= S_REQ;
                cnt_q[bus.downstream_txreq_entry_id]   <= '0;
            end

            // Placed after the AR update so a completing beat wins over the
            // REQ->FILL move for the same entry.
            if (r_live) begin
                if (bus.mem_r_last) begin
                    state_q[r_id] <= S_DONE;
                    cnt_q[r_id]   <= '0;
                end else if (r_cnt == LAST_SLOT) begin
                    cnt_q[r_id] <= '0;
                end else begin
                    cnt_q[r_id] <= r_cnt + CNT_ONE;
                end
            end

            if (r_bad) begin
                err_q <= 1'b1;
            end

            // After a return the output stays empty for one cycle, then the
            // next DONE entry is loaded.
            if (rx_fire) begin
                rx_vld_q         <= 1'b0;
                state_q[rx_id_q] <= S_IDLE;
            end else if (!rx_vld_q && sel_found) begin
                rx_vld_q <= 1'b1;
                rx_pld_q <= sel_line;
                rx_id_q  <= sel_id;
            end

            case ({tx_fire, rx_fire})
                2'b10:   out_cnt_q <= out_cnt_q + OCNT_ONE;
                2'b01:   out_cnt_q <= out_cnt_q - OCNT_ONE;
                default: out_cnt_q <= out_cnt_q;
            endcase
        end
    end

    // Line storage needs no reset: a new request always rewrites its beats
    // before the line can be returned.
    always_ff @(posedge clk) begin
        if (r_live) begin
            line_q[r_id][int'(r_cnt)*BEAT_W +: BEAT_W] <= bus.mem_r_data;
        end
    end

    always_comb begin
        state_dbg = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            state_dbg[2*i +: 2] = state_q[i];
        end
    end

    assign bus.mem_ar_vld                = ar_vld_q;
    assign bus.mem_ar_addr               = ar_addr_q;
    assign bus.mem_ar_id                 = ar_id_q;
    assign bus.downstream_rxdat_vld      = rx_vld_q;
    assign bus.downstream_rxdat_pld      = rx_pld_q;
    assign bus.downstream_rxdat_entry_id = rx_id_q;
    assign outstanding_cnt               = out_cnt_q;
    assign err_o                         = err_q;

endmodule

// File: doc/icache_refill_bridge.md
Name: icache_refill_bridge

Overview:
Downstream neighbour of icache_top. Consumes icache miss requests (downstream_txreq with entry_id) and issues line-aligned read requests to the memory/L2 port. It collects multi-beat read data, possibly out of order by ID, into per-entry line buffers. It returns each completed line to icache_top on downstream_rxdat together with its entry_id.

Parameters:
ADDR_WIDTH, 32, request/memory address width
ENTRY_NUM, 8, icache miss entries (max outstanding)
ENTRY_ID_W, 3, log2(ENTRY_NUM)
LINE_W, 256, cache line width in bits
BEAT_W, 64, memory data beat width; BEATS = LINE_W/BEAT_W (4), must be an integer ≥2

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-high reset (asserted when 1)
downstream_txreq_vld  in  1  miss request valid
downstream_txreq_rdy  out  1  miss request accepted
downstream_txreq_pld  in  ADDR_WIDTH  miss address (byte)
downstream_txreq_entry_id  in  ENTRY_ID_W  icache miss entry
downstream_rxdat_vld  out  1  refill line valid
downstream_rxdat_rdy  in  1  icache accepts line
downstream_rxdat_pld  out  LINE_W  refill line, beat0 in bits [BEAT_W-1:0]
downstream_rxdat_entry_id  out  ENTRY_ID_W  entry the line belongs to
mem_ar_vld  out  1  memory read request valid
mem_ar_rdy  in  1  memory accepts request
mem_ar_addr  out  ADDR_WIDTH  line-aligned address
mem_ar_id  out  ENTRY_ID_W  = entry_id
mem_r_vld  in  1  read beat valid
mem_r_rdy  out  1  beat accepted
mem_r_data  in  BEAT_W  beat data
mem_r_id  in  ENTRY_ID_W  beat owner
mem_r_last  in  1  final beat of line
outstanding_cnt  out  ENTRY_ID_W+1  number of pending entries
err_o  out  1  sticky protocol error

Behaviour:
- Reset: all vld outputs 0, mem_r_rdy 0 during reset, pend/done vectors 0, beat counters 0, outstanding_cnt 0, err_o 0. Reset mid-transfer discards all state, including partial lines.
- Per-entry state: IDLE -> REQ (AR pending in the single AR holding register) -> FILL (beats arriving) -> DONE (line complete, awaiting return) -> IDLE. pend[i] = state != IDLE.
- AR holding register is a single slot. downstream_txreq_rdy = !pend[txreq_entry_id] && (AR slot empty || mem_ar_rdy). Requests to a busy entry are stalled, never dropped.
- On txreq handshake, the AR slot loads {addr & ~(LINE_W/8-1), id}. mem_ar_vld rises the next cycle and holds with stable addr/id until mem_ar_rdy. AR handshake moves the entry to FILL. Back-to-back requests with mem_ar_rdy=1 sustain 1 request/cycle.
- mem_r_rdy = 1 whenever out of reset. A beat to entry id in FILL (or REQ, to tolerate early data) writes beat slot cnt[id] and increments cnt[id].
- Beat with mem_r_last=1 and cnt==BEATS-1: entry -> DONE, cnt clears.
- Error cases (set err_o, sticky until reset):
  - last=1 with cnt!=BEATS-1, or last=0 with cnt==BEATS-1: the entry still goes to DONE on last, or wraps cnt to 0 on the over-run beat.
  - A beat to an IDLE/DONE entry: the beat is accepted and discarded.
- Return: lowest-index DONE entry is selected when rxdat is idle. The registered output (vld, pld, entry_id) stays stable until downstream_rxdat_rdy. The handshake returns the entry to IDLE. Next selection is visible the following cycle. Max throughput is 1 line per 2 cycles.
- Latency: last beat at cycle N -> downstream_rxdat_vld at N+1 if the output is idle. Min txreq handshake to mem_ar_vld = 1 cycle.
- Same-cycle events:
  - A return handshake for id X and a txreq for id X in the same cycle: txreq is not accepted (pend evaluated before clear). It is accepted the next cycle.
  - A beat to id A and a return of id B in the same cycle: both proceed.
- outstanding_cnt = popcount(pend). It increments on txreq handshake and decrements on return handshake; simultaneous events leave it unchanged. Max value is ENTRY_NUM.

Test Plan:
- Single miss: txreq addr 0x0000_1234 id 2 -> mem_ar_addr 0x0000_1220, id 2. Return 4 beats 0x11..,0x22..,0x33..,0x44.. (last on 4th) -> rxdat_pld = {0x44..,0x33..,0x22..,0x11..}, entry_id 2, vld at last+1.
- Out-of-order: ids 0,1,2 requested, data returned order 2,0,1 -> lines returned 2,0,1 with correct data. outstanding_cnt goes 3->0.
- Backpressure:
  - mem_ar_rdy low 5 cycles -> ar addr/id stable, txreq_rdy low once the slot is full.
  - rxdat_rdy low 4 cycles -> pld stable, a second DONE entry waits.
- Busy entry: a second txreq to pending id 5 -> txreq_rdy=0 until the id-5 line is returned. It is accepted the cycle after the return handshake.
- Protocol error: last asserted on beat 2 -> err_o=1 (sticky), entry returned. Beat to an idle id -> accepted, err_o=1.
- Reset mid-fill: assert rst_n=1 after 2 beats -> all vld 0, outstanding_cnt 0, err_o 0. A fresh request completes normally.
